// File: rtl/lsu.sv
// rtl/lsu.sv - load/store unit bridging a pipeline memory stage to a single-word memory port
// Aligns and replicates store data, extracts and extends load data, flags misaligned/illegal/timeout.

module lsu #(
  parameter int TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_wen,
  input  logic [2:0]  req_funct3,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  output logic [31:0] resp_rdata,
  output logic        resp_err,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic [7:0]  mem_wmask,
  output logic        mem_wen,
  output logic        mem_valid,
  input  logic [31:0] mem_rdata,
  input  logic        mem_ack
);

  typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

  // Counter only needs to reach TIMEOUT-1: that cycle is the last one mem_valid is held.
  localparam int CW = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT);
  localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);

  state_t        state, state_d;
  logic [CW-1:0] cnt;
  logic [2:0]    f3_q;
  logic [31:0]   addr_q;
  logic          wen_q;
  logic [31:0]   mwdata_q;
  logic [3:0]    mwmask_q;
  logic [31:0]   rdata_q;
  logic          err_q;

  logic          size_legal;
  logic          misaligned;
  logic          req_bad;
  logic [31:0]   st_data;
  logic [3:0]    st_mask;
  logic [31:0]   rd_shift;
  logic [31:0]   ld_data;
  logic          timeout_hit;

  always_comb begin
    size_legal = 1'b0;
    case (req_funct3)
      3'b000, 3'b001, 3'b010: size_legal = 1'b1;
      3'b100, 3'b101:         size_legal = ~req_wen;
      default:                size_legal = 1'b0;
    endcase
  end

  assign misaligned = ((req_funct3 == 3'b001 || req_funct3 == 3'b101) && req_addr[0]) ||
                      ((req_funct3 == 3'b010) && (req_addr[1:0] != 2'b00));
  assign req_bad    = ~size_legal | misaligned;

  always_comb begin
    st_data = req_wdata;
    st_mask = 4'b1111;
    case (req_funct3[1:0])
      2'b00: begin
        st_data = {4{req_wdata[7:0]}};
        st_mask = 4'b0001 << req_addr[1:0];
      end
      2'b01: begin
        st_data = {2{req_wdata[15:0]}};
        st_mask = 4'b0011 << req_addr[1:0];
      end
      default: begin
        st_data = req_wdata;
        st_mask = 4'b1111;
      end
    endcase
  end

  assign rd_shift = mem_rdata >> {addr_q[1:0], 3'b000};

  always_comb begin
    ld_data = mem_rdata;
    case (f3_q)
      3'b000:  ld_data = {{24{rd_shift[7]}}, rd_shift[7:0]};
      3'b001:  ld_data = {{16{rd_shift[15]}}, rd_shift[15:0]};
      3'b100:  ld_data = {24'b0, rd_shift[7:0]};
      3'b101:  ld_data = {16'b0, rd_shift[15:0]};
      default: ld_data = mem_rdata;
    endcase
  end

  assign timeout_hit = (cnt == CNT_LAST);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_d;
  end

  always_comb begin
    state_d    = state;
    req_ready  = 1'b0;
    mem_valid  = 1'b0;
    resp_valid = 1'b0;
    case (state)
      IDLE: begin
        req_ready = 1'b1;
        if (req_valid) state_d = req_bad ? RESP : ACCESS;
      end
      ACCESS: begin
        mem_valid = 1'b1;
        if (mem_ack || timeout_hit) state_d = RESP;
      end
      RESP: begin
        resp_valid = 1'b1;
        state_d    = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Memory-side and response outputs are zero whenever their phase is not active.
  assign mem_addr   = mem_valid ? {addr_q[31:2], 2'b00} : 32'b0;
  assign mem_wdata  = mem_valid ? mwdata_q : 32'b0;
  assign mem_wmask  = mem_valid ? {4'b0000, mwmask_q} : 8'b0;
  assign mem_wen    = mem_valid & wen_q;
  assign resp_rdata = resp_valid ? rdata_q : 32'b0;
  assign resp_err   = resp_valid & err_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt      <= '0;
      f3_q     <= 3'b0;
      addr_q   <= 32'b0;
      wen_q    <= 1'b0;
      mwdata_q <= 32'b0;
      mwmask_q <= 4'b0;
      rdata_q  <= 32'b0;
      err_q    <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (req_valid) begin
            f3_q     <= req_funct3;
            addr_q   <= req_addr;
            wen_q    <= req_wen;
            mwdata_q <= st_data;
            mwmask_q <= req_wen ? st_mask : 4'b0000;
            rdata_q  <= 32'b0;
            err_q    <= req_bad;
            cnt      <= '0;
          end
        end
        ACCESS: begin
          if (mem_ack) begin
            rdata_q <= wen_q ? 32'b0 : ld_data;
            err_q   <= 1'b0;
          end else if (timeout_hit) begin
            rdata_q <= 32'b0;
            err_q   <= 1'b1;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: doc/lsu.md
LSU -- requirements
Module: lsu

Interface
REQ-001 Parameter TIMEOUT, default 255: maximum cycles ACCESS waits for mem_ack before an error response.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst  input  1  reset, asynchronous, active-high.
REQ-004 req_valid  input  1  pipeline memory-stage request present.
REQ-005 req_ready  output  1  LSU can accept a request.
REQ-006 req_wen  input  1  1 = store, 0 = load.
REQ-007 req_funct3  input  3  size code: 000 B, 001 H, 010 W, 100 BU, 101 HU.
REQ-008 req_addr  input  32  byte address.
REQ-009 req_wdata  input  32  store data, right-aligned.
REQ-010 resp_valid  output  1  one-cycle completion pulse.
REQ-011 resp_rdata  output  32  extended load data; 0 for stores and errors.
REQ-012 resp_err  output  1  misaligned, illegal-size or timeout, valid with resp_valid.
REQ-013 mem_addr  output  32  word-aligned address to memory.
REQ-014 mem_wdata  output  32  lane-replicated store data.
REQ-015 mem_wmask  output  8  byte-enable mask; bits [7:4] always 0.
REQ-016 mem_wen  output  1  memory write enable.
REQ-017 mem_valid  output  1  memory access request.
REQ-018 mem_rdata  input  32  memory read word.
REQ-019 mem_ack  input  1  memory access complete; mem_rdata valid this cycle.

Function
REQ-020 FSM states SHALL be IDLE, ACCESS, RESP; all outputs SHALL be registered or decoded from registered state only.
REQ-021 IDLE: req_ready=1, mem_valid=0; req_valid=1 captures funct3, addr, wdata, wen in the same edge.
REQ-022 Captured request misaligned (H/HU with addr[0]=1; W with addr[1:0]!=0) or funct3 not in REQ-007 (including BU/HU with wen=1) SHALL go to RESP with resp_err=1 and no memory access.
REQ-023 Otherwise the FSM SHALL go to ACCESS; ACCESS holds mem_valid=1 with stable mem_addr/mem_wdata/mem_wmask/mem_wen until mem_ack.
REQ-024 mem_addr = {addr[31:2], 2'b00}.
REQ-025 Store mask: B = 0001 << addr[1:0]; H = 0011 << addr[1:0]; W = 1111; load mask = 0000, mem_wen=0.
REQ-026 Store data: B = {4{wdata[7:0]}}, H = {2{wdata[15:0]}}, W = wdata.
REQ-027 Load extract: byte/halfword at bit offset addr[1:0]*8 of mem_rdata; B/H sign-extend, BU/HU zero-extend, W unchanged.
REQ-028 mem_ack in ACCESS SHALL capture extracted data and go to RESP with resp_err=0.
REQ-029 A wait counter SHALL start at 0 on ACCESS entry and increment each cycle without ack; reaching TIMEOUT SHALL go to RESP with resp_err=1, resp_rdata=0, mem_valid dropped.
REQ-030 RESP: resp_valid=1 for exactly one cycle, req_ready=0, then IDLE; no response backpressure.
REQ-031 Minimum latency: request accepted edge N, mem_valid high cycle N+1, ack in N+1 gives resp_valid in cycle N+2; a new request is accepted no earlier than cycle N+3.
REQ-032 mem_ack outside ACCESS SHALL be ignored.
REQ-033 Error responses SHALL complete in 2 cycles (accept, RESP) with mem_valid never asserted.

Reset
REQ-034 rst=1 SHALL immediately force IDLE, counter 0, req_ready=1, resp_valid=0, resp_err=0, resp_rdata=0, mem_valid=0, mem_wen=0, mem_wmask=0, mem_addr=0, mem_wdata=0.
REQ-035 Reset during ACCESS SHALL abandon the access with no response; a subsequent ack SHALL be ignored.

Verification
REQ-036 Load B addr 0x80000003, mem_rdata 0x80FF1234, ack next cycle -> mem_addr 0x80000000, resp_rdata 0xFFFFFF80, resp_err 0, resp_valid at N+2.
REQ-037 Load HU addr 0x80000002, mem_rdata 0xBEEF0000 -> resp_rdata 0x0000BEEF; same with H -> 0xFFFFBEEF.
REQ-038 Store H addr 0x10000006, wdata 0x0000ABCD -> mem_wdata 0xABCDABCD, mem_wmask 0x0C, mem_wen 1, mem_addr 0x10000004, resp_rdata 0.
REQ-039 Store W addr 0x10000002 -> mem_valid never asserted, resp_err 1 one cycle after acceptance.
REQ-040 TIMEOUT=4, load W, no ack -> mem_valid high 4 cycles, then resp_valid=1, resp_err=1, resp_rdata 0.
REQ-041 rst pulsed mid-ACCESS, ack one cycle after release -> mem_valid low immediately, no resp_valid, req_ready=1.
